// File: rtl/cam_seq_pkg.sv
// Shared definitions for the camera power-up sequencer.
// Holds the state width and encoding, the timer width, and a timer
// increment constant so arithmetic stays at full timer width.
package cam_seq_pkg;

  localparam int STATE_W = 3;
  localparam int TMR_W   = 32;

  localparam logic [STATE_W-1:0] ST_PWDN      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RST       = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT      = 3'd2;
  localparam logic [STATE_W-1:0] ST_CFG_START = 3'd3;
  localparam logic [STATE_W-1:0] ST_CFG_WAIT  = 3'd4;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

  localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

  typedef enum logic [STATE_W-1:0] {
    S_PWDN      = ST_PWDN,
    S_RST       = ST_RST,
    S_WAIT      = ST_WAIT,
    S_CFG_START = ST_CFG_START,
    S_CFG_WAIT  = ST_CFG_WAIT,
    S_RUN       = ST_RUN,
    S_FAULT     = ST_FAULT
  } seq_state_e;

endpackage

// File: rtl/seq_timer.sv
// Clear-on-entry up-counter with a terminal compare.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (counter to zero)
//   i_clr  - clear the counter (asserted on the cycle a state is left)
//   i_len  - length of the current state in cycles (>=1); 0 means untimed
//   o_term - high while the counter sits on the last cycle (len-1)
// The counter holds once it reaches len-1, so it never wraps. An untimed
// state passes length 0, which parks the counter at all-ones.
module seq_timer
  import cam_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [TMR_W-1:0] i_len,
  output logic             o_term
);

  logic [TMR_W-1:0] tmr;

  assign o_term = (tmr == (i_len - TMR_ONE));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      tmr <= '0;
    end else if (!o_term) begin
      tmr <= tmr + TMR_ONE;
    end
  end

endmodule

// File: rtl/cam_pwrup_seq.sv
// Power-up and reset sequencer for the OV7670 camera path.
// Sequence: power-down -> RESET# low -> settle -> config start -> wait for
// config result -> run. A config error or timeout power-cycles the camera
// again until the retry budget is spent, then the camera is parked in fault.
// Ports:
//   i_clk        - system clock
//   i_rst        - synchronous active-high reset
//   i_restart    - pulse; restarts the sequence from RUN or FAULT
//   i_cfg_done   - config engine success (looked at only while waiting)
//   i_cfg_err    - config engine error (looked at only while waiting)
//   o_cam_pwdn   - camera PWDN pin, active high
//   o_cam_rstn   - camera RESET# pin, active low
//   o_cfg_start  - one-cycle start pulse to the config engine
//   o_pipe_rstn  - capture pipeline reset, active low
//   o_ready      - camera configured, pipeline running
//   o_fault      - retry budget exhausted
//   o_retry_cnt  - retries consumed in the current sequence
// All outputs are decoded from the next state and registered, so they change
// on the same edge as the state register with no input-to-output path.
module cam_pwrup_seq
  import cam_seq_pkg::*;
#(
  parameter logic [31:0] PWDN_CYCLES        = 32'd100000,
  parameter logic [31:0] RST_LOW_CYCLES     = 32'd50000,
  parameter logic [31:0] RST_WAIT_CYCLES    = 32'd150000,
  parameter logic [31:0] CFG_TIMEOUT_CYCLES = 32'd5000000,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_restart,
  input  logic       i_cfg_done,
  input  logic       i_cfg_err,
  output logic       o_cam_pwdn,
  output logic       o_cam_rstn,
  output logic       o_cfg_start,
  output logic       o_pipe_rstn,
  output logic       o_ready,
  output logic       o_fault,
  output logic [3:0] o_retry_cnt
);

  localparam logic [3:0] MAX_R = MAX_RETRIES[3:0];

  seq_state_e       state, state_nxt;
  logic [3:0]       retry, retry_nxt;
  logic [TMR_W-1:0] tmr_len;
  logic             tmr_term;
  logic             tmr_clr;
  logic             cfg_fail;

  logic pwdn_nxt, rstn_nxt, start_nxt, pipe_nxt, ready_nxt, fault_nxt;

  // Any state change restarts the dwell count for the state being entered.
  assign tmr_clr = (state_nxt != state);

  seq_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (tmr_clr),
    .i_len  (tmr_len),
    .o_term (tmr_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_PWDN;
      retry <= '0;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    tmr_len   = '0;
    cfg_fail  = 1'b0;

    case (state)
      S_PWDN: begin
        tmr_len = PWDN_CYCLES;
        if (tmr_term) state_nxt = S_RST;
      end
      S_RST: begin
        tmr_len = RST_LOW_CYCLES;
        if (tmr_term) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tmr_len = RST_WAIT_CYCLES;
        if (tmr_term) state_nxt = S_CFG_START;
      end
      S_CFG_START: begin
        state_nxt = S_CFG_WAIT;
      end
      S_CFG_WAIT: begin
        tmr_len = CFG_TIMEOUT_CYCLES;
        // Error beats done; done beats a timeout landing on the same cycle.
        if (i_cfg_err) begin
          cfg_fail = 1'b1;
        end else if (i_cfg_done) begin
          state_nxt = S_RUN;
        end else if (tmr_term) begin
          cfg_fail = 1'b1;
        end
      end
      S_RUN, S_FAULT: begin
        if (i_restart) begin
          state_nxt = S_PWDN;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = S_PWDN;
        retry_nxt = '0;
      end
    endcase

    if (cfg_fail) begin
      if (retry < MAX_R) begin
        retry_nxt = retry + 4'd1;
        state_nxt = S_PWDN;
      end else begin
        state_nxt = S_FAULT;
      end
    end

    pwdn_nxt  = 1'b0;
    rstn_nxt  = 1'b0;
    start_nxt = 1'b0;
    pipe_nxt  = 1'b0;
    ready_nxt = 1'b0;
    fault_nxt = 1'b0;
    case (state_nxt)
      S_PWDN:      pwdn_nxt = 1'b1;
      S_RST:       ;
      S_WAIT:      rstn_nxt = 1'b1;
      S_CFG_START: begin
        rstn_nxt  = 1'b1;
        start_nxt = 1'b1;
      end
      S_CFG_WAIT:  rstn_nxt = 1'b1;
      S_RUN: begin
        rstn_nxt  = 1'b1;
        pipe_nxt  = 1'b1;
        ready_nxt = 1'b1;
      end
      S_FAULT: begin
        pwdn_nxt  = 1'b1;
        fault_nxt = 1'b1;
      end
      default:     pwdn_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cam_pwdn  <= 1'b1;
      o_cam_rstn  <= 1'b0;
      o_cfg_start <= 1'b0;
      o_pipe_rstn <= 1'b0;
      o_ready     <= 1'b0;
      o_fault     <= 1'b0;
      o_retry_cnt <= '0;
    end else begin
      o_cam_pwdn  <= pwdn_nxt;
      o_cam_rstn  <= rstn_nxt;
      o_cfg_start <= start_nxt;
      o_pipe_rstn <= pipe_nxt;
      o_ready     <= ready_nxt;
      o_fault     <= fault_nxt;
      o_retry_cnt <= retry_nxt;
    end
  end

endmodule

// File: tb/tb_cam_pwrup_seq.sv
// Testbench for cam_pwrup_seq: directed scenarios with fixed expected values,
// then randomized inputs checked against a dwell-count phase model.
module tb_cam_pwrup_seq;

  localparam int P_PWDN = 4;
  localparam int P_RSTL = 3;
  localparam int P_RSTW = 5;
  localparam int P_TO   = 20;
  localparam int P_MAXR = 2;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_restart = 1'b0;
  logic       i_cfg_done = 1'b0;
  logic       i_cfg_err = 1'b0;
  logic       o_cam_pwdn, o_cam_rstn, o_cfg_start, o_pipe_rstn, o_ready, o_fault;
  logic [3:0] o_retry_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: phase 0 PWDN,1 RST,2 WAIT,3 CFG_START,4 CFG_WAIT,5 RUN,6 FAULT.
  // m_age is the 1-based count of cycles spent in the current phase.
  int m_ph = 0;
  int m_age = 1;
  int m_retry = 0;

  cam_pwrup_seq #(
    .PWDN_CYCLES        (32'(P_PWDN)),
    .RST_LOW_CYCLES     (32'(P_RSTL)),
    .RST_WAIT_CYCLES    (32'(P_RSTW)),
    .CFG_TIMEOUT_CYCLES (32'(P_TO)),
    .MAX_RETRIES        (P_MAXR)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_restart   (i_restart),
    .i_cfg_done  (i_cfg_done),
    .i_cfg_err   (i_cfg_err),
    .o_cam_pwdn  (o_cam_pwdn),
    .o_cam_rstn  (o_cam_rstn),
    .o_cfg_start (o_cfg_start),
    .o_pipe_rstn (o_pipe_rstn),
    .o_ready     (o_ready),
    .o_fault     (o_fault),
    .o_retry_cnt (o_retry_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int nph;
    bit fail;
    nph  = m_ph;
    fail = 1'b0;
    if (i_rst) begin
      m_ph = 0; m_age = 1; m_retry = 0;
      return;
    end
    case (m_ph)
      0: if (m_age == P_PWDN) nph = 1;
      1: if (m_age == P_RSTL) nph = 2;
      2: if (m_age == P_RSTW) nph = 3;
      3: nph = 4;
      4: begin
        if (i_cfg_err) fail = 1'b1;
        else if (i_cfg_done) nph = 5;
        else if (m_age == P_TO) fail = 1'b1;
      end
      default: if (i_restart) begin nph = 0; m_retry = 0; end
    endcase
    if (fail) begin
      if (m_retry < P_MAXR) begin m_retry++; nph = 0; end
      else nph = 6;
    end
    if (nph != m_ph || fail) m_age = 1;
    else m_age++;
    m_ph = nph;
  endtask

  task automatic check_model();
    chk("m_pwdn",  32'(o_cam_pwdn),  32'(m_ph == 0 || m_ph == 6));
    chk("m_rstn",  32'(o_cam_rstn),  32'(m_ph >= 2 && m_ph <= 5));
    chk("m_start", 32'(o_cfg_start), 32'(m_ph == 3));
    chk("m_pipe",  32'(o_pipe_rstn), 32'(m_ph == 5));
    chk("m_ready", 32'(o_ready),     32'(m_ph == 5));
    chk("m_fault", 32'(o_fault),     32'(m_ph == 6));
    chk("m_retry", 32'(o_retry_cnt), 32'(m_retry));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    cyc++;
    #1;
    check_model();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Leaves the sequencer in cycle 1 (first cycle after reset release).
  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    chk("rst_pwdn",  32'(o_cam_pwdn),  32'd1);
    chk("rst_rstn",  32'(o_cam_rstn),  32'd0);
    chk("rst_start", 32'(o_cfg_start), 32'd0);
    chk("rst_pipe",  32'(o_pipe_rstn), 32'd0);
    chk("rst_ready", 32'(o_ready),     32'd0);
    chk("rst_fault", 32'(o_fault),     32'd0);
    chk("rst_retry", 32'(o_retry_cnt), 32'd0);
    i_rst = 1'b0;
    cyc = 1;
  endtask

  initial begin
    // Nominal bring-up
    do_reset();
    run_to(4);  chk("nom_c4_pwdn", 32'(o_cam_pwdn), 32'd1);
    run_to(5);  chk("nom_c5_pwdn", 32'(o_cam_pwdn), 32'd0);
                chk("nom_c5_rstn", 32'(o_cam_rstn), 32'd0);
    run_to(7);  chk("nom_c7_rstn", 32'(o_cam_rstn), 32'd0);
    run_to(8);  chk("nom_c8_rstn", 32'(o_cam_rstn), 32'd1);
    run_to(12); chk("nom_c12_start", 32'(o_cfg_start), 32'd0);
    run_to(13); chk("nom_c13_start", 32'(o_cfg_start), 32'd1);
    run_to(14); chk("nom_c14_start", 32'(o_cfg_start), 32'd0);
    run_to(20); chk("nom_c20_ready", 32'(o_ready), 32'd0);
    i_cfg_done = 1'b1;
    run_to(21);
    i_cfg_done = 1'b0;
    chk("nom_c21_ready", 32'(o_ready), 32'd1);
    chk("nom_c21_pipe",  32'(o_pipe_rstn), 32'd1);

    // Restart from RUN
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    chk("rs_run_ready", 32'(o_ready), 32'd0);
    chk("rs_run_pipe",  32'(o_pipe_rstn), 32'd0);
    chk("rs_run_pwdn",  32'(o_cam_pwdn), 32'd1);
    chk("rs_run_retry", 32'(o_retry_cnt), 32'd0);

    // Timeout retries into FAULT (each attempt spans 33 cycles)
    do_reset();
    run_to(33);  chk("to_c33_pwdn", 32'(o_cam_pwdn), 32'd0);
    run_to(34);  chk("to_c34_pwdn", 32'(o_cam_pwdn), 32'd1);
                 chk("to_c34_retry", 32'(o_retry_cnt), 32'd1);
    run_to(67);  chk("to_c67_retry", 32'(o_retry_cnt), 32'd2);
    run_to(99);  chk("to_c99_fault", 32'(o_fault), 32'd0);
    run_to(100); chk("to_c100_fault", 32'(o_fault), 32'd1);
                 chk("to_c100_retry", 32'(o_retry_cnt), 32'd2);
                 chk("to_c100_pwdn", 32'(o_cam_pwdn), 32'd1);
                 chk("to_c100_rstn", 32'(o_cam_rstn), 32'd0);
    run_to(110); chk("to_c110_fault", 32'(o_fault), 32'd1);
    i_restart = 1'b1;
    step();
    i_restart = 1'b0;
    chk("rs_flt_fault", 32'(o_fault), 32'd0);
    chk("rs_flt_pwdn",  32'(o_cam_pwdn), 32'd1);
    chk("rs_flt_retry", 32'(o_retry_cnt), 32'd0);

    // Error and done together in CFG_WAIT
    do_reset();
    run_to(16);
    i_cfg_err = 1'b1; i_cfg_done = 1'b1;
    step();
    i_cfg_err = 1'b0; i_cfg_done = 1'b0;
    chk("ed_pwdn",  32'(o_cam_pwdn), 32'd1);
    chk("ed_retry", 32'(o_retry_cnt), 32'd1);
    chk("ed_ready", 32'(o_ready), 32'd0);

    // Stale done held from cycle 1
    i_cfg_done = 1'b1;
    do_reset();
    run_to(12); chk("st_c12_start", 32'(o_cfg_start), 32'd0);
    run_to(13); chk("st_c13_start", 32'(o_cfg_start), 32'd1);
    run_to(14); chk("st_c14_ready", 32'(o_ready), 32'd0);
    run_to(15); chk("st_c15_ready", 32'(o_ready), 32'd1);
    i_cfg_done = 1'b0;

    // Reset during CFG_START
    do_reset();
    run_to(13);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("mr_start", 32'(o_cfg_start), 32'd0);
    chk("mr_pwdn",  32'(o_cam_pwdn), 32'd1);
    chk("mr_rstn",  32'(o_cam_rstn), 32'd0);
    cyc = 1;
    run_to(4); chk("mr_c4_pwdn", 32'(o_cam_pwdn), 32'd1);
    run_to(5); chk("mr_c5_pwdn", 32'(o_cam_pwdn), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      i_cfg_done = ($urandom_range(0, 15) == 0);
      i_cfg_err  = ($urandom_range(0, 31) == 0);
      i_restart  = ($urandom_range(0, 23) == 0);
      i_rst      = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
